// File: rtl/uart_packet_framer_plnk_if.sv
// uart_packet_framer_plnk_if: packet request and UART TX byte bundle for the plank-feedback framer.
// Ports: master = framer side (takes requests and UART done, drives bytes, busy, done, errors);
//        slave  = environment side (drives requests and UART done, observes framer outputs).
interface uart_packet_framer_plnk_if #(
  parameter int unsigned TX_PACKET_LEN = 32
);
  // Packet request side
  logic                           i_en;
  logic [(TX_PACKET_LEN-1)*8-1:0] i_data;
  logic                           i_data_valid;
  logic                           o_busy;

  // UART TX byte side
  logic [7:0]                     o_uart_tx_data;
  logic                           o_uart_tx_dv;
  logic                           i_uart_tx_done;

  // Status
  logic                           o_tx_done;
  logic [1:0]                     o_tx_error;
  logic                           o_tx_error_dv;

  modport master (
    input  i_en, i_data, i_data_valid, i_uart_tx_done,
    output o_busy, o_uart_tx_data, o_uart_tx_dv, o_tx_done, o_tx_error, o_tx_error_dv
  );

  modport slave (
    output i_en, i_data, i_data_valid, i_uart_tx_done,
    input  o_busy, o_uart_tx_data, o_uart_tx_dv, o_tx_done, o_tx_error, o_tx_error_dv
  );
endinterface

// File: rtl/uart_packet_framer_plnk.sv
// uart_packet_framer_plnk: frames a payload word as HEADER, payload bytes (LSB byte first),
//   XOR checksum, FOOTER, handing one byte at a time to a UART TX byte interface.
// Latency: HEADER strobe one cycle after acceptance; each later strobe one cycle after the
//   UART done pulse; tx_done one cycle after the footer's done. The UART paces the stream
//   (one byte in flight); requests arriving while busy are dropped with error code 2'b01.
// Ports: i_clk, i_rst_n (async active-low), bus (uart_packet_framer_plnk_if.master).
// Optional: define UART_PKT_TX_TIMEOUT_EN to abort (code 2'b11) when the UART stays silent
//   for more than TX_TIMEOUT clocks; without it the framer waits indefinitely.
module uart_packet_framer_plnk #(
  parameter logic [7:0]  HEADER        = 8'hAA,
  parameter logic [7:0]  FOOTER        = 8'h55,
  parameter int unsigned TX_PACKET_LEN = 32,
  parameter int unsigned TX_TIMEOUT    = 18000
) (
  input logic                      i_clk,
  input logic                      i_rst_n,
  uart_packet_framer_plnk_if.master bus
);

  localparam int unsigned PAYLOAD_W = (TX_PACKET_LEN - 1) * 8;
  localparam int unsigned IDX_W     = $clog2(TX_PACKET_LEN + 2) + 1;

  // Byte index map: 0 header, 1..LEN-1 payload, LEN checksum, LEN+1 footer.
  localparam logic [IDX_W-1:0] IDX_LAST_PAY = IDX_W'(TX_PACKET_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_CHK      = IDX_W'(TX_PACKET_LEN);
  localparam logic [IDX_W-1:0] IDX_FOOT     = IDX_W'(TX_PACKET_LEN + 1);

  localparam logic [1:0] ERR_DROP    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [0:0] {
    SM_IDLE = 1'b0,
    SM_WAIT = 1'b1
  } state_t;

  state_t               state, state_nx;

  logic [PAYLOAD_W-1:0] r_shift, shift_nx;
  logic [7:0]           r_checksum, checksum_nx;
  logic [IDX_W-1:0]     r_idx, idx_nx, idx_inc;

  logic                 busy_q, busy_nx;
  logic [7:0]           tx_data_q, tx_data_nx;
  logic                 tx_dv_q, tx_dv_nx;
  logic                 tx_done_q, tx_done_nx;
  logic [1:0]           tx_err_q, tx_err_nx;
  logic                 tx_err_dv_q, tx_err_dv_nx;

  logic                 timeout_hit;

`ifdef UART_PKT_TX_TIMEOUT_EN
  logic [31:0]          r_cnt, cnt_nx;

  // Strictly greater: the abort fires on the cycle the counter has passed the limit.
  assign timeout_hit = (r_cnt > 32'(TX_TIMEOUT));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= cnt_nx;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign idx_inc = r_idx + IDX_W'(1);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= SM_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and registered-output computation
  always_comb begin
    state_nx     = state;
    shift_nx     = r_shift;
    checksum_nx  = r_checksum;
    idx_nx       = r_idx;
    busy_nx      = busy_q;
    tx_data_nx   = tx_data_q;
    tx_dv_nx     = 1'b0;
    tx_done_nx   = 1'b0;
    tx_err_nx    = tx_err_q;
    tx_err_dv_nx = 1'b0;
`ifdef UART_PKT_TX_TIMEOUT_EN
    cnt_nx       = r_cnt;
`endif

    case (state)
      SM_IDLE: begin
        if (bus.i_en && bus.i_data_valid) begin
          shift_nx    = bus.i_data;
          checksum_nx = '0;
          idx_nx      = '0;
          tx_data_nx  = HEADER;
          tx_dv_nx    = 1'b1;
          busy_nx     = 1'b1;
          state_nx    = SM_WAIT;
`ifdef UART_PKT_TX_TIMEOUT_EN
          cnt_nx      = '0;
`endif
        end
      end

      SM_WAIT: begin
`ifdef UART_PKT_TX_TIMEOUT_EN
        cnt_nx = r_cnt + 32'd1;
`endif
        // Any request while a packet is in flight is refused, independent of i_en;
        // a timeout in the same cycle overwrites the code below.
        if (bus.i_data_valid) begin
          tx_err_nx    = ERR_DROP;
          tx_err_dv_nx = 1'b1;
        end

        // A done pulse always wins over a coincident timeout.
        if (bus.i_uart_tx_done) begin
`ifdef UART_PKT_TX_TIMEOUT_EN
          cnt_nx = '0;
`endif
          idx_nx = idx_inc;
          if (idx_inc <= IDX_LAST_PAY) begin
            tx_data_nx  = r_shift[7:0];
            checksum_nx = r_checksum ^ r_shift[7:0];
            shift_nx    = r_shift >> 8;
            tx_dv_nx    = 1'b1;
          end else if (idx_inc == IDX_CHK) begin
            tx_data_nx = r_checksum;
            tx_dv_nx   = 1'b1;
          end else if (idx_inc == IDX_FOOT) begin
            tx_data_nx = FOOTER;
            tx_dv_nx   = 1'b1;
          end else begin
            // Footer has left the UART: packet complete.
            tx_done_nx = 1'b1;
            busy_nx    = 1'b0;
            state_nx   = SM_IDLE;
          end
        end else if (timeout_hit) begin
          tx_err_nx    = ERR_TIMEOUT;
          tx_err_dv_nx = 1'b1;
          busy_nx      = 1'b0;
          state_nx     = SM_IDLE;
        end
      end

      default: begin
        busy_nx  = 1'b0;
        state_nx = SM_IDLE;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift     <= '0;
      r_checksum  <= '0;
      r_idx       <= '0;
      busy_q      <= 1'b0;
      tx_data_q   <= '0;
      tx_dv_q     <= 1'b0;
      tx_done_q   <= 1'b0;
      tx_err_q    <= '0;
      tx_err_dv_q <= 1'b0;
    end else begin
      r_shift     <= shift_nx;
      r_checksum  <= checksum_nx;
      r_idx       <= idx_nx;
      busy_q      <= busy_nx;
      tx_data_q   <= tx_data_nx;
      tx_dv_q     <= tx_dv_nx;
      tx_done_q   <= tx_done_nx;
      tx_err_q    <= tx_err_nx;
      tx_err_dv_q <= tx_err_dv_nx;
    end
  end

  assign bus.o_busy         = busy_q;
  assign bus.o_uart_tx_data = tx_data_q;
  assign bus.o_uart_tx_dv   = tx_dv_q;
  assign bus.o_tx_done      = tx_done_q;
  assign bus.o_tx_error     = tx_err_q;
  assign bus.o_tx_error_dv  = tx_err_dv_q;

endmodule

// File: tb/tb_uart_packet_framer_plnk.sv
// tb_uart_packet_framer_plnk: directed bench for uart_packet_framer_plnk with a 3-byte payload.
// Ports: none; drives the interface as the UART/requester and compares against hand-computed bytes.
module tb_uart_packet_framer_plnk;

  localparam int LEN = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_packet_framer_plnk_if #(.TX_PACKET_LEN(LEN)) bus ();

  uart_packet_framer_plnk #(
    .HEADER        (8'hAA),
    .FOOTER        (8'h55),
    .TX_PACKET_LEN (LEN),
    .TX_TIMEOUT    (100)
  ) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.master)
  );

  int checks = 0;
  int failures = 0;

  // Passive monitor: records every strobed byte and counts pulses.
  logic [7:0] wire_q[$];
  int         done_cnt = 0;
  int         err_cnt = 0;
  int         unstable = 0;
  logic [1:0] last_err = 2'b00;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_uart_tx_dv) wire_q.push_back(bus.o_uart_tx_data);
      else if (bus.o_uart_tx_data !== prev_data) unstable++;
      prev_data = bus.o_uart_tx_data;
      if (bus.o_tx_done) done_cnt++;
      if (bus.o_tx_error_dv) begin
        err_cnt++;
        last_err = bus.o_tx_error;
      end
    end else begin
      prev_data = 8'h00;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request; returns in the cycle where the header strobe should be visible.
  task automatic start_req(input logic [23:0] d);
    bus.i_data       = d;
    bus.i_data_valid = 1'b1;
    tick();
    bus.i_data_valid = 1'b0;
  endtask

  // UART model: wait dly cycles after a strobe, pulse done, sample the cycle after.
  task automatic respond(input int dly, output logic dv_s, output logic done_s, output logic busy_s);
    repeat (dly) tick();
    bus.i_uart_tx_done = 1'b1;
    tick();
    bus.i_uart_tx_done = 1'b0;
    dv_s   = bus.o_uart_tx_dv;
    done_s = bus.o_tx_done;
    busy_s = bus.o_busy;
  endtask

  // Drives a full packet after the header; reports how many bytes missed their one-cycle slot.
  task automatic finish_packet(input int lo, input int hi, output int late,
                               output logic end_done, output logic end_busy);
    logic dv_s, dn_s, bz_s;
    late = 0;
    for (int i = 1; i < LEN + 2; i++) begin
      respond($urandom_range(hi, lo), dv_s, dn_s, bz_s);
      if (dv_s !== 1'b1) late++;
    end
    respond($urandom_range(hi, lo), dv_s, end_done, end_busy);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_en = 1'b1;
    bus.i_data = '0;
    bus.i_data_valid = 1'b0;
    bus.i_uart_tx_done = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bus.o_busy, bus.o_uart_tx_dv, bus.o_tx_done, bus.o_tx_error_dv} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_strobes got=%b exp=0000",
               {bus.o_busy, bus.o_uart_tx_dv, bus.o_tx_done, bus.o_tx_error_dv});
    end
    checks++;
    if ({bus.o_uart_tx_data, bus.o_tx_error} !== 10'h000) begin
      failures++;
      $display("FAIL reset_data got=%h exp=000", {bus.o_uart_tx_data, bus.o_tx_error});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] exp [6];
    int late;
    logic e_done, e_busy;
    int d0;
    exp = '{8'hAA, 8'h11, 8'h22, 8'h44, 8'h77, 8'h55};
    wire_q.delete();
    d0 = done_cnt;
    start_req(24'h442211);
    checks++;
    if ({bus.o_uart_tx_dv, bus.o_busy, bus.o_uart_tx_data} !== {2'b11, 8'hAA}) begin
      failures++;
      $display("FAIL basic_header got=%b_%b_%h exp=1_1_aa",
               bus.o_uart_tx_dv, bus.o_busy, bus.o_uart_tx_data);
    end
    finish_packet(3, 3, late, e_done, e_busy);
    checks++;
    if (late !== 0) begin failures++; $display("FAIL basic_latency late=%0d exp=0", late); end
    checks++;
    if ({e_done, e_busy} !== 2'b10) begin
      failures++;
      $display("FAIL basic_end done_busy=%b%b exp=10", e_done, e_busy);
    end
    tick();
    checks++;
    if (wire_q.size() !== 6) begin
      failures++;
      $display("FAIL basic_count got=%0d exp=6", wire_q.size());
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (wire_q[i] !== exp[i]) begin
        failures++;
        $display("FAIL basic_byte%0d got=%h exp=%h", i, wire_q[i], exp[i]);
      end
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      failures++;
      $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt - d0);
    end
  endtask

  task automatic test_done_latency();
    logic [7:0] exp [6];
    int late;
    logic e_done, e_busy;
    exp = '{8'hAA, 8'h0F, 8'h5A, 8'hC3, 8'h96, 8'h55};
    wire_q.delete();
    unstable = 0;
    start_req(24'hC35A0F);
    finish_packet(1, 50, late, e_done, e_busy);
    tick();
    checks++;
    if (late !== 0) begin failures++; $display("FAIL lat_dv late=%0d exp=0", late); end
    checks++;
    if (unstable !== 0) begin failures++; $display("FAIL lat_hold changes=%0d exp=0", unstable); end
    checks++;
    if ({e_done, e_busy} !== 2'b10) begin
      failures++;
      $display("FAIL lat_end done_busy=%b%b exp=10", e_done, e_busy);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (wire_q[i] !== exp[i]) begin
        failures++;
        $display("FAIL lat_byte%0d got=%h exp=%h", i, wire_q[i], exp[i]);
      end
    end
  endtask

  task automatic test_busy_drop();
    logic [7:0] exp [6];
    logic dv_s, dn_s, bz_s;
    int e0;
    exp = '{8'hAA, 8'h01, 8'h02, 8'h03, 8'h00, 8'h55};
    wire_q.delete();
    e0 = err_cnt;
    start_req(24'h030201);
    tick();
    bus.i_data = 24'hFFFFFF;
    bus.i_data_valid = 1'b1;
    tick();
    bus.i_data_valid = 1'b0;
    bus.i_data = 24'h030201;
    tick();
    checks++;
    if ({err_cnt - e0, last_err} !== {32'd1, 2'b01}) begin
      failures++;
      $display("FAIL drop_mid errs=%0d code=%b exp=1,01", err_cnt - e0, last_err);
    end
    for (int i = 1; i < LEN + 2; i++) respond(2, dv_s, dn_s, bz_s);
    // Footer done and a new request in the same cycle.
    tick();
    bus.i_uart_tx_done = 1'b1;
    bus.i_data_valid = 1'b1;
    tick();
    bus.i_uart_tx_done = 1'b0;
    bus.i_data_valid = 1'b0;
    checks++;
    if ({bus.o_tx_done, bus.o_busy, bus.o_tx_error_dv, bus.o_tx_error} !== 5'b10101) begin
      failures++;
      $display("FAIL drop_footer done_busy_errdv_err=%b%b%b%b exp=10101",
               bus.o_tx_done, bus.o_busy, bus.o_tx_error_dv, bus.o_tx_error);
    end
    repeat (5) tick();
    checks++;
    if ({wire_q.size(), bus.o_busy} !== {32'd6, 1'b0}) begin
      failures++;
      $display("FAIL drop_no_restart bytes=%0d busy=%b exp=6,0", wire_q.size(), bus.o_busy);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (wire_q[i] !== exp[i]) begin
        failures++;
        $display("FAIL drop_byte%0d got=%h exp=%h", i, wire_q[i], exp[i]);
      end
    end
  endtask

  task automatic test_enable();
    logic [7:0] exp [6];
    int late, e0;
    logic e_done, e_busy;
    exp = '{8'hAA, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h55};
    wire_q.delete();
    e0 = err_cnt;
    bus.i_en = 1'b0;
    bus.i_data = 24'h112233;
    bus.i_data_valid = 1'b1;
    repeat (5) tick();
    bus.i_data_valid = 1'b0;
    tick();
    checks++;
    if ({wire_q.size(), err_cnt - e0, bus.o_busy} !== {32'd0, 32'd0, 1'b0}) begin
      failures++;
      $display("FAIL en_gate bytes=%0d errs=%0d busy=%b exp=0,0,0",
               wire_q.size(), err_cnt - e0, bus.o_busy);
    end
    bus.i_en = 1'b1;
    start_req(24'h0000FF);
    bus.i_en = 1'b0;
    finish_packet(1, 1, late, e_done, e_busy);
    tick();
    bus.i_en = 1'b1;
    checks++;
    if ({late, e_done, e_busy} !== {32'd0, 2'b10}) begin
      failures++;
      $display("FAIL en_drop_mid late=%0d done_busy=%b%b exp=0,10", late, e_done, e_busy);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (wire_q[i] !== exp[i]) begin
        failures++;
        $display("FAIL en_byte%0d got=%h exp=%h", i, wire_q[i], exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp [6];
    logic dv_s, dn_s, bz_s;
    int late;
    logic e_done, e_busy;
    exp = '{8'hAA, 8'h30, 8'h20, 8'h10, 8'h00, 8'h55};
    start_req(24'hA1B2C3);
    respond(2, dv_s, dn_s, bz_s);
    respond(2, dv_s, dn_s, bz_s);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.o_busy, bus.o_uart_tx_dv, bus.o_tx_done, bus.o_tx_error_dv,
         bus.o_uart_tx_data, bus.o_tx_error} !== 14'h0) begin
      failures++;
      $display("FAIL rst_mid outs=%h exp=0000", {bus.o_busy, bus.o_uart_tx_dv, bus.o_tx_done,
               bus.o_tx_error_dv, bus.o_uart_tx_data, bus.o_tx_error});
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    wire_q.delete();
    start_req(24'h102030);
    checks++;
    if ({bus.o_uart_tx_dv, bus.o_uart_tx_data} !== {1'b1, 8'hAA}) begin
      failures++;
      $display("FAIL rst_next_header got=%b_%h exp=1_aa", bus.o_uart_tx_dv, bus.o_uart_tx_data);
    end
    finish_packet(1, 4, late, e_done, e_busy);
    tick();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (wire_q[i] !== exp[i]) begin
        failures++;
        $display("FAIL rst_byte%0d got=%h exp=%h", i, wire_q[i], exp[i]);
      end
    end
  endtask

`ifdef UART_PKT_TX_TIMEOUT_EN
  task automatic test_timeout();
    logic [7:0] exp [6];
    int k, d0, late;
    logic hit, e_done, e_busy;
    exp = '{8'hAA, 8'h81, 8'h00, 8'h7E, 8'hFF, 8'h55};
    d0 = done_cnt;
    hit = 1'b0;
    k = 0;
    start_req(24'h000001);
    while (!hit && k < 300) begin
      tick();
      k++;
      hit = bus.o_tx_error_dv;
    end
    checks++;
    if ({hit, k} !== {1'b1, 32'd102}) begin
      failures++;
      $display("FAIL to_time hit=%b cycles=%0d exp=1,102", hit, k);
    end
    checks++;
    if ({bus.o_tx_error, bus.o_busy, bus.o_tx_done} !== 4'b1100) begin
      failures++;
      $display("FAIL to_state err_busy_done=%b exp=1100",
               {bus.o_tx_error, bus.o_busy, bus.o_tx_done});
    end
    tick();
    wire_q.delete();
    start_req(24'h7E0081);
    finish_packet(1, 3, late, e_done, e_busy);
    tick();
    checks++;
    if (done_cnt - d0 !== 1) begin
      failures++;
      $display("FAIL to_done_pulses got=%0d exp=1", done_cnt - d0);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (wire_q[i] !== exp[i]) begin
        failures++;
        $display("FAIL to_byte%0d got=%h exp=%h", i, wire_q[i], exp[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_done_latency();
    test_busy_drop();
    test_enable();
    test_reset_mid();
`ifdef UART_PKT_TX_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_packet_framer_plnk.md
# uart_packet_framer_plnk

- Transmit-side packet framer for the plank-feedback UART link.
- Takes a parallel payload word and streams `HEADER`, payload bytes LSB-byte first, an XOR checksum byte, then `FOOTER`, one byte at a time, to the UART TX byte interface.
- It is the sending end of the link whose receiver validates header, checksum and footer; byte order and checksum rule match that receiver exactly.

## Interface
- `HEADER`, 8'hAA, first byte on wire.
- `FOOTER`, 8'h55, last byte on wire.
- `TX_PACKET_LEN`, 32, bytes between header and footer including checksum; payload = `TX_PACKET_LEN-1` bytes; must be ≥ 2.
- `TX_TIMEOUT`, 18000, clocks to wait for UART byte completion before abort.
- `i_clk` in 1: clock.
- `i_rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `i_en` in 1: enables acceptance of new packets.
- `i_data` in `(TX_PACKET_LEN-1)*8`: payload; byte k = `i_data[8k+7:8k]`.
- `i_data_valid` in 1: packet request, sampled each clock.
- `o_busy` out 1: high from acceptance until packet end or abort.
- `o_uart_tx_data` out 8: byte to UART TX.
- `o_uart_tx_dv` out 1: one-cycle strobe, byte valid.
- `i_uart_tx_done` in 1: UART TX pulse, current byte fully sent.
- `o_tx_done` out 1: one-cycle pulse, footer sent.
- `o_tx_error` out 2: error code; holds last value.
- `o_tx_error_dv` out 1: one-cycle strobe, new error code.

## Operation
- **States:** `SM_IDLE`, `SM_WAIT`.
- **Byte index** `r_idx`, width `$clog2(TX_PACKET_LEN+2)+1`.
  - 0 = header.
  - 1..`TX_PACKET_LEN-1` = payload.
  - `TX_PACKET_LEN` = checksum.
  - `TX_PACKET_LEN+1` = footer.
- **`SM_IDLE`:** if `i_en && i_data_valid`, then:
  - latch `i_data` into shift register `r_shift`;
  - clear `r_checksum`, set `r_idx` to 0;
  - drive `o_uart_tx_data=HEADER`, `o_uart_tx_dv=1`, `o_busy=1`;
  - clear timeout counter; go to `SM_WAIT`.
- **`SM_WAIT`:** timeout counter increments each clock. On `i_uart_tx_done`:
  - clear the counter and increment `r_idx`.
  - Next byte is a payload byte: send `r_shift[7:0]`, `r_checksum ^= r_shift[7:0]`, `r_shift >>= 8`, pulse dv.
  - Next byte is the checksum: send `r_checksum`, pulse dv.
  - Next byte is the footer: send `FOOTER`, pulse dv.
  - Footer just completed: pulse `o_tx_done`, `o_busy=0`, go to `SM_IDLE`.
- **Checksum:** XOR of payload bytes, seed 0; header, checksum and footer bytes are excluded.
- **Request while not idle:**
  - any `i_data_valid=1` in `SM_WAIT` is dropped;
  - `o_tx_error=2'b01` and `o_tx_error_dv` pulse;
  - the in-flight packet is unaffected.
- **`i_en`:**
  - gates acceptance only; `i_data_valid` with `i_en=0` is ignored silently.
  - Dropping `i_en` mid-packet does not stop the packet.
- **Timeout:** counter > `TX_TIMEOUT` with no `i_uart_tx_done` that cycle causes:
  - `o_tx_error=2'b11` and `o_tx_error_dv` pulse;
  - `o_busy=0`, no `o_tx_done`, return to `SM_IDLE`.
- **Simultaneous done and timeout:** done wins.
- **Simultaneous drop error and timeout:** code 2'b11 wins.
- **Illegal state:** go to `SM_IDLE`, `o_busy=0`.

## Timing
- **Reset values (all outputs 0):** `o_busy`, `o_uart_tx_data`, `o_uart_tx_dv`, `o_tx_done`, `o_tx_error`, `o_tx_error_dv`. State `SM_IDLE`, counters cleared.
- All outputs are registered.
- **Acceptance latency:** an acceptance edge puts `HEADER` with dv=1 in the next cycle; `o_busy` rises in that same cycle.
- **Per-byte latency:** each subsequent dv appears in the cycle after the `i_uart_tx_done` cycle.
- `o_uart_tx_data` holds its value until the next dv.
- **End of packet:** `o_tx_done` and `o_busy=0` appear in the cycle after the footer's `i_uart_tx_done`.
- **Next request:** a request presented while `o_busy=0` is accepted. One sampled in the same cycle as the footer's done counts as "while busy" and is dropped with error 2'b01.
- **Wire length:** `TX_PACKET_LEN+2` bytes.
- **Reset mid-packet:** immediate return to reset values; no partial-packet completion.
- `i_uart_tx_done` in `SM_IDLE` is ignored.

## Configuration
- **`UART_PKT_TX_TIMEOUT_EN` defined:** timeout counter (32-bit) and abort behaviour as above.
- **Undefined:**
  - no counter; `SM_WAIT` waits indefinitely for `i_uart_tx_done`;
  - code 2'b11 is never produced;
  - `TX_TIMEOUT` is unused.

## Test plan
- **Basic packet:** `TX_PACKET_LEN=4`, `i_data=24'h442211`, UART done 3 clocks after each dv -> wire AA,11,22,44,77,55; exactly 6 dv pulses; one `o_tx_done`; `o_busy` falls with it.
- **Done latency:** done delays randomised 1–50 clocks -> every dv exactly one cycle after its done; data stable between strobes.
- **Timeout:** macro on, `TX_TIMEOUT=100`, no done after header -> `o_tx_error=2'b11` pulse ~101 clocks after header dv, `o_busy=0`. A following request sends a full correct packet.
- **Request while busy:** second request mid-packet -> `o_tx_error=2'b01` pulse; first packet bytes unchanged. Request on the footer-done cycle is also dropped.
- **Reset mid-packet:** `i_rst_n` low after 2nd payload byte -> all outputs 0 same cycle. Next request starts with AA.
- **Enable gating:** `i_en=0` with `i_data_valid=1` -> no dv, no error. `i_en` dropped after header -> packet completes to 55.
